// File: rtl/lm75_i2c_target_if.sv
// I2C bus bundle between the board initiator and the LM75 target.
// SCL/SDA are the resolved bus levels; sda_oe is the target's open-drain pull-down.
interface lm75_i2c_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/lm75_i2c_target.sv
// LM75 temperature-sensor emulation on an I2C target port.
// SCL/SDA are oversampled on clk; the target never stretches SCL and only
// changes its SDA pull-down on SCL falling edges.
module lm75_i2c_target #(
  parameter logic [6:0] ADDR_BASE   = 7'h48,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          a_pins,
  lm75_i2c_target_if.slave    bus,
  input  logic [8:0]          temp_i,
  output logic                os_o,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q, tx_q, msb_q;
  logic [1:0] ptr_q, wr_idx_q;
  logic       rd_idx_q, rw_q;
  logic [4:0] conf_q;
  logic [8:0] thyst_q, tos_q, snap_q;
  logic       sda_oe_q, busy_q, active_q, os_q;
  logic [8:0] rd_val_d;
  logic [7:0] rd_byte_d;

  // Bring SCL/SDA into the clk domain; reset to the idle-bus level (both high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_q;
  assign scl_fall_s = ~scl_s & scl_prev_q;
  // SDA may only move while SCL is high for START/STOP conditions.
  assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Select the next byte to transmit from the pointer and byte parity.
  always_comb begin
    rd_val_d  = snap_q;
    rd_byte_d = 8'h00;
    case (ptr_q)
      2'd0:    rd_val_d = snap_q;
      2'd2:    rd_val_d = thyst_q;
      2'd3:    rd_val_d = tos_q;
      default: rd_val_d = snap_q;
    endcase
    if (ptr_q == 2'd1) begin
      rd_byte_d = {3'b000, conf_q};
    end else if (rd_idx_q) begin
      rd_byte_d = {rd_val_d[0], 7'b0000000};
    end else begin
      rd_byte_d = rd_val_d[8:1];
    end
  end

  // Protocol FSM: address match, register writes and read shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      tx_q      <= 8'h00;
      msb_q     <= 8'h00;
      ptr_q     <= 2'd0;
      wr_idx_q  <= 2'd0;
      rd_idx_q  <= 1'b0;
      rw_q      <= 1'b0;
      conf_q    <= 5'h00;
      thyst_q   <= 9'h096;
      tos_q     <= 9'h0A0;
      snap_q    <= 9'h000;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else if (start_s) begin
      state_q   <= ADDR;
      bit_cnt_q <= 4'd0;
      sda_oe_q  <= 1'b0;
      rd_idx_q  <= 1'b0;
      wr_idx_q  <= 2'd0;
    end else if (stop_s) begin
      state_q  <= IDLE;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise_s) begin
            shift_q   <= {shift_q[6:0], sda_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == {ADDR_BASE[6:3], a_pins}) begin
              state_q  <= ADDR_ACK;
              sda_oe_q <= 1'b1;
              busy_q   <= 1'b1;
              rw_q     <= shift_q[0];
              if (shift_q[0]) snap_q <= temp_i;
            end else begin
              state_q <= IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_q <= 4'd0;
            if (rw_q) begin
              tx_q     <= {rd_byte_d[6:0], 1'b0};
              sda_oe_q <= ~rd_byte_d[7];
              rd_idx_q <= ~rd_idx_q;
              state_q  <= RD_BYTE;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise_s) begin
            shift_q   <= {shift_q[6:0], sda_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
            sda_oe_q <= 1'b1;
            state_q  <= WR_ACK;
            if (wr_idx_q != 2'd3) wr_idx_q <= wr_idx_q + 2'd1;
            if (wr_idx_q == 2'd0) begin
              ptr_q <= shift_q[1:0];
            end else begin
              case (ptr_q)
                2'd1: if (wr_idx_q == 2'd1) conf_q <= shift_q[4:0];
                2'd2: begin
                  if (wr_idx_q == 2'd1) msb_q <= shift_q;
                  else if (wr_idx_q == 2'd2) thyst_q <= {msb_q, shift_q[7]};
                end
                2'd3: begin
                  if (wr_idx_q == 2'd1) msb_q <= shift_q;
                  else if (wr_idx_q == 2'd2) tos_q <= {msb_q, shift_q[7]};
                end
                default: ;
              endcase
            end
          end
        end
        WR_ACK: begin
          if (scl_fall_s) begin
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= 4'd0;
            state_q   <= WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_rise_s) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end else if (scl_fall_s) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 4'd0;
              state_q   <= RD_ACK;
            end else begin
              sda_oe_q <= ~tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          // A NACK ends the read on the rising edge; an ACK loads the next byte on the fall.
          if (scl_rise_s && sda_s) begin
            state_q <= IGNORE;
          end else if (scl_fall_s) begin
            tx_q     <= {rd_byte_d[6:0], 1'b0};
            sda_oe_q <= ~rd_byte_d[7];
            rd_idx_q <= ~rd_idx_q;
            state_q  <= RD_BYTE;
          end
        end
        IDLE, IGNORE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Comparator-mode OS with THYST/TOS hysteresis, polarity from CONF[2].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      os_q     <= 1'b1;
    end else begin
      if ($signed(temp_i) > $signed(tos_q)) begin
        active_q <= 1'b1;
      end else if ($signed(temp_i) < $signed(thyst_q)) begin
        active_q <= 1'b0;
      end
      os_q <= active_q ^ ~conf_q[2];
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign busy       = busy_q;
  assign os_o       = os_q;

endmodule

// File: tb/tb_lm75_i2c_target.sv
// Directed bench for the LM75 I2C target: bit-banged initiator, open-drain bus.
module tb_lm75_i2c_target;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] a_pins;
  logic [8:0] temp_i;
  logic       os_o, busy;
  logic       m_scl, m_sda;
  logic       ack, s;
  logic [7:0] d;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         oe_cnt = 0;
  int         oe_mark;

  localparam int Q = 8;

  always #5 clk = ~clk;

  lm75_i2c_target_if bus ();
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  lm75_i2c_target dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_pins (a_pins),
    .bus    (bus.slave),
    .temp_i (temp_i),
    .os_o   (os_o),
    .busy   (busy)
  );

  // Count clocks during which the target pulls SDA low.
  always @(posedge clk) if (bus.sda_oe) oe_cnt <= oe_cnt + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_clk(input logic b, output logic smp);
    m_sda = b;
    wq();
    m_scl = 1'b1;
    repeat (Q/2) @(negedge clk);
    smp = bus.sda_i;
    repeat (Q/2) @(negedge clk);
    m_scl = 1'b0;
    wq();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wq();
    m_scl = 1'b1;
    wq();
    m_sda = 1'b0;
    wq();
    m_scl = 1'b0;
    wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wq();
    m_scl = 1'b1;
    wq();
    m_sda = 1'b1;
    wq();
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic a);
    logic t;
    for (int i = 7; i >= 0; i--) bit_clk(v[i], t);
    bit_clk(1'b1, a);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] v);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      bit_clk(1'b1, t);
      v[i] = t;
    end
    bit_clk(nack, t);
  endtask

  initial begin
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; a_pins = 3'b000; temp_i = 9'h032;
    repeat (3) @(negedge clk);
    check("rst_sda_oe", bus.sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_os", os_o, 1'b1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: set pointer 0, repeated START, read TEMP 0x032
    i2c_start();
    wr_byte(8'h90, ack);  check("t1_addr_w_ack", ack, 1'b0);
    check("t1_busy", busy, 1'b1);
    wr_byte(8'h00, ack);  check("t1_ptr_ack", ack, 1'b0);
    i2c_start();
    wr_byte(8'h91, ack);  check("t1_addr_r_ack", ack, 1'b0);
    rd_byte(1'b0, d);     check("t1_byte0", d, 8'h19);
    rd_byte(1'b1, d);     check("t1_byte1", d, 8'h00);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t1_busy_stop", busy, 1'b0);

    // 2: negative temperature, snapshot holds across bytes
    temp_i = 9'h1CE;
    i2c_start();
    wr_byte(8'h91, ack);  check("t2_ack", ack, 1'b0);
    rd_byte(1'b0, d);     check("t2_byte0", d, 8'hE7);
    temp_i = 9'h001;
    rd_byte(1'b1, d);     check("t2_byte1_snap", d, 8'h00);
    i2c_stop();

    // 3: write TOS and read it back four bytes
    i2c_start();
    wr_byte(8'h90, ack);  check("t3_addr_ack", ack, 1'b0);
    wr_byte(8'h03, ack);  check("t3_ptr_ack", ack, 1'b0);
    wr_byte(8'h55, ack);  check("t3_msb_ack", ack, 1'b0);
    wr_byte(8'h80, ack);  check("t3_lsb_ack", ack, 1'b0);
    i2c_stop();
    i2c_start();
    wr_byte(8'h91, ack);  check("t3_rd_ack", ack, 1'b0);
    rd_byte(1'b0, d);     check("t3_tos_b0", d, 8'h55);
    rd_byte(1'b0, d);     check("t3_tos_b1", d, 8'h80);
    rd_byte(1'b0, d);     check("t3_tos_b2", d, 8'h55);
    rd_byte(1'b1, d);     check("t3_tos_b3", d, 8'h80);
    i2c_stop();

    // 3b: lone first THYST byte is discarded
    i2c_start();
    wr_byte(8'h90, ack);
    wr_byte(8'h02, ack);
    wr_byte(8'h12, ack);  check("t3b_lone_ack", ack, 1'b0);
    i2c_stop();
    i2c_start();
    wr_byte(8'h91, ack);
    rd_byte(1'b0, d);     check("t3b_thyst_b0", d, 8'h4B);
    rd_byte(1'b1, d);     check("t3b_thyst_b1", d, 8'h00);
    i2c_stop();

    // 4: foreign address is ignored, then our address is answered
    oe_mark = oe_cnt;
    i2c_start();
    wr_byte(8'h9E, ack);  check("t4_nack", ack, 1'b1);
    check("t4_busy", busy, 1'b0);
    wr_byte(8'h00, ack);  check("t4_data_nack", ack, 1'b1);
    i2c_stop();
    repeat (2) @(negedge clk);
    check("t4_no_drive", oe_cnt - oe_mark, 16'd0);
    i2c_start();
    wr_byte(8'h91, ack);  check("t4_next_ack", ack, 1'b0);
    rd_byte(1'b1, d);
    i2c_stop();

    // 5: OS hysteresis from defaults, then polarity flip via CONF
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    temp_i = 9'h090; repeat (4) @(negedge clk); check("t5_os_090", os_o, 1'b1);
    temp_i = 9'h0A0; repeat (4) @(negedge clk); check("t5_os_0A0", os_o, 1'b1);
    temp_i = 9'h0A1; repeat (4) @(negedge clk); check("t5_os_0A1", os_o, 1'b0);
    temp_i = 9'h096; repeat (4) @(negedge clk); check("t5_os_096", os_o, 1'b0);
    temp_i = 9'h095; repeat (4) @(negedge clk); check("t5_os_095", os_o, 1'b1);
    i2c_start();
    wr_byte(8'h90, ack);
    wr_byte(8'h01, ack);
    wr_byte(8'hE4, ack);  check("t5_conf_ack", ack, 1'b0);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t5_os_inv", os_o, 1'b0);
    i2c_start();
    wr_byte(8'h91, ack);
    rd_byte(1'b0, d);     check("t5_conf_b0", d, 8'h04);
    rd_byte(1'b1, d);     check("t5_conf_b1", d, 8'h04);
    i2c_stop();
    temp_i = 9'h0A1; repeat (4) @(negedge clk); check("t5_os_inv_hot", os_o, 1'b1);

    // 6: async reset while the target drives read bit 3
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    temp_i = 9'h032;
    i2c_start();
    wr_byte(8'h91, ack);  check("t6_ack", ack, 1'b0);
    bit_clk(1'b1, s);
    bit_clk(1'b1, s);
    m_sda = 1'b1;
    wq();
    m_scl = 1'b1;
    repeat (Q/2) @(negedge clk);
    check("t6_oe_before", bus.sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_oe_async", bus.sda_oe, 1'b0);
    check("t6_busy_async", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (Q/2) @(negedge clk);
    m_scl = 1'b0;
    wq();
    i2c_stop();
    i2c_start();
    wr_byte(8'h91, ack);  check("t6_re_ack", ack, 1'b0);
    rd_byte(1'b0, d);     check("t6_byte0", d, 8'h19);
    rd_byte(1'b1, d);     check("t6_byte1", d, 8'h00);
    i2c_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
